uart_rx_fifo: RTL

//  Parametrised successor to the UART receiver in the PC-to-interface-board bridge.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART receive path.
//   parity_t   : parity mode encoding (none / odd / even)
//   rx_state_t : receiver FSM states
//   calc_div   : rounded clock divisor that produces the oversample tick
//   baud_ok    : true when that divisor keeps the line-rate error within 2%
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int calc_div(input longint clk_hz, input longint baud,
                                  input longint os);
    longint den;
    den = baud * os;
    if (den <= 0) return 0;
    return int'((clk_hz + den / 2) / den);
  endfunction

  function automatic bit baud_ok(input longint clk_hz, input longint baud,
                                 input longint os);
    longint div;
    longint act;
    longint err;
    div = longint'(calc_div(clk_hz, baud, os));
    if (div < 1) return 1'b0;
    act = clk_hz / (div * os);
    err = (act > baud) ? (act - baud) : (baud - act);
    // err/baud <= 0.02
    return (err * 50 <= baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   push        : write push_data when not full (or when popping while full)
//   pop         : remove head word; ignored when empty
//   rd_data     : head word, forced to 0 while empty
//   empty, full : status flags
//   level       : number of stored words
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty   = (r_count == '0);
  assign full    = (r_count == LW'(DEPTH));
  assign level   = r_count;
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with checked start/parity/stop bits, a FWFT
// word buffer, and hysteretic active-low RTS flow control.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx          : asynchronous serial input, idle high
//   rts         : 0 = host may send, 1 = stop
//   out_data    : FIFO head word (valid while out_valid)
//   out_valid   : FIFO non-empty
//   out_ready   : consumer pop request
//   level       : words stored
//   parity_err  : 1-cycle pulse, word dropped for bad parity
//   frame_err   : 1-cycle pulse, word dropped for stop bit = 0
//   overrun     : 1-cycle pulse, word dropped because the FIFO is full
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int CLK_HZ     = 7372800,
  parameter  int BAUD       = 115200,
  parameter  int OVERSAMPLE = 16,
  parameter  int DATA_BITS  = 8,
  parameter  int PARITY     = 0,
  parameter  int FIFO_DEPTH = 16,
  parameter  int RTS_HIGH   = 12,
  parameter  int RTS_LOW    = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 rts,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LVL_W-1:0]     level,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int      DIV      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int      OS_W     = $clog2(OVERSAMPLE);
  localparam int      BIT_W    = $clog2(DATA_BITS);
  localparam parity_t PAR_MODE = parity_t'(PARITY);

  if (DIV < 1 || !baud_ok(CLK_HZ, BAUD, OVERSAMPLE)) begin : g_bad_baud
    $error("uart_rx_fifo: divisor %0d invalid or baud error above 2%%", DIV);
  end
  if (RTS_LOW >= RTS_HIGH) begin : g_bad_rts
    $error("uart_rx_fifo: RTS_LOW must be below RTS_HIGH");
  end

  logic                 r_sync1, r_sync2, r_rx_prev;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [OS_W-1:0]      r_os_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  rx_state_t            r_state, w_state_nxt;
  logic                 r_rts, r_parity_err, r_frame_err, r_overrun;

  logic                 w_rx, w_fall, w_tick, w_mid_start, w_mid_bit;
  logic                 w_start, w_os_clr, w_shift_en, w_par_chk;
  logic                 w_push, w_perr, w_ferr, w_par_bad_now;
  logic                 w_pop, w_push_acc, w_overrun, w_empty, w_full;
  logic [DATA_BITS-1:0] w_rd_data;
  logic [LVL_W-1:0]     w_level, w_level_nxt;

  // Synchroniser, plus one extra flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_rx        = r_sync2;
  assign w_fall      = r_rx_prev & ~r_sync2;
  assign w_tick      = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_mid_start = w_tick && (r_os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
  assign w_mid_bit   = w_tick && (r_os_cnt == OS_W'(OVERSAMPLE - 1));
  assign w_par_bad_now = (PAR_MODE == PAR_ODD) ? ~(^r_shift ^ w_rx)
                                               :  (^r_shift ^ w_rx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_os_clr    = 1'b0;
    w_shift_en  = 1'b0;
    w_par_chk   = 1'b0;
    w_push      = 1'b0;
    w_perr      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_mid_start) begin
          w_os_clr    = 1'b1;
          w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_mid_bit) begin
          w_os_clr   = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1))
            w_state_nxt = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_mid_bit) begin
          w_os_clr    = 1'b1;
          w_par_chk   = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_mid_bit) begin
          w_os_clr = 1'b1;
          // A low stop bit outranks any pending parity error.
          if (!w_rx) begin
            w_ferr      = 1'b1;
            w_state_nxt = ST_BREAK;
          end else begin
            w_perr      = r_par_bad;
            w_push      = ~r_par_bad;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (w_rx) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tick and bit counters. The divider free-runs but is re-phased on each
  // start edge so the mid-bit samples line up with this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_par_bad <= 1'b0;
    end else begin
      if (w_start || w_tick) r_div_cnt <= '0;
      else                   r_div_cnt <= r_div_cnt + 1'b1;
      if (w_start || w_os_clr) r_os_cnt <= '0;
      else if (w_tick)         r_os_cnt <= r_os_cnt + 1'b1;
      if (w_start)         r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_start)        r_par_bad <= 1'b0;
      else if (w_par_chk) r_par_bad <= w_par_bad_now;
    end
  end

  // LSB arrives first, so shift right and insert at the top.
  always_ff @(posedge clk) begin
    if (w_shift_en) r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (r_shift),
    .pop       (w_pop),
    .rd_data   (w_rd_data),
    .empty     (w_empty),
    .full      (w_full),
    .level     (w_level)
  );

  assign w_pop       = out_ready & ~w_empty;
  assign w_push_acc  = w_push & (~w_full | w_pop);
  assign w_overrun   = w_push & w_full & ~w_pop;
  assign w_level_nxt = w_level + LVL_W'(w_push_acc) - LVL_W'(w_pop);

  // RTS tracks the level the FIFO will hold next cycle, so it reacts on the
  // same edge as the push that crosses a threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rts        <= 1'b1;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_level_nxt >= LVL_W'(RTS_HIGH))     r_rts <= 1'b1;
      else if (w_level_nxt <= LVL_W'(RTS_LOW)) r_rts <= 1'b0;
      r_parity_err <= w_perr;
      r_frame_err  <= w_ferr;
      r_overrun    <= w_overrun;
    end
  end

  assign rts        = r_rts;
  assign out_data   = w_rd_data;
  assign out_valid  = ~w_empty;
  assign level      = w_level;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
